// File: rtl/cpu_sink.sv
// cpu_sink -- receiving end of one CPU's 64-bit data stream.
//
// Accepts words over a data_vld/data_rdy handshake, applies pseudo-random
// backpressure from a 16-bit LFSR, counts and signs every accepted word and
// raises a sticky done once the producer reports transactions_done.
//
// Optional feature macro: CPU_SINK_CHECK_EN
//   When defined, every accepted word is checked against a locally re-derived
//   xorshift64* sequence (ITERATIONS steps per word). Mismatches set error and
//   latch the index of the first bad word. When undefined, error only reflects
//   the final word count and first_err_idx stays 0xFFFFFFFF.
//
// Parameters
//   EXPECTED_NB   words the producer must deliver
//   ITERATIONS    xorshift64* steps between consecutive words (checker only)
//   STALL_WEIGHT  0..15, larger means more backpressure
//
// Ports
//   clk                in   clock
//   rst_n              in   synchronous active-low reset
//   cpu_index   [31:0] in   producer index; seeds LFSR and checker
//   data_vld           in   producer word valid
//   data        [63:0] in   producer word
//   transactions_done  in   producer finished
//   data_rdy           out  sink ready (registered)
//   rx_count    [31:0] out  words accepted
//   signature   [63:0] out  running rotate-xor signature
//   error              out  sticky mismatch / count error
//   first_err_idx[31:0] out index of first mismatching word, all-ones if none
//   done               out  sticky end-of-test
//
// state  | meaning
// -------+--------------------------------------------------
// READY  | accepting words, watching for end of stream
// CHECK  | stepping the reference generator, then comparing
// DONE   | terminal; outputs frozen until reset

module cpu_sink #(
  parameter int unsigned EXPECTED_NB  = 1000,
  parameter int unsigned ITERATIONS   = 20000000,
  parameter int unsigned STALL_WEIGHT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_index,
  input  logic        data_vld,
  input  logic [63:0] data,
  input  logic        transactions_done,
  output logic        data_rdy,
  output logic [31:0] rx_count,
  output logic [63:0] signature,
  output logic        error,
  output logic [31:0] first_err_idx,
  output logic        done
);

  localparam logic [3:0]  STALL_W  = 4'(STALL_WEIGHT);
  localparam logic [31:0] EXP_NB   = 32'(EXPECTED_NB);
  localparam logic [63:0] XS_SEED  = 64'hdeadbeefdeadbeef;
  localparam logic [63:0] XS_MULT  = 64'h5821657736338717;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_nxt;
  logic [15:0] lfsr_q, lfsr_nxt;
  logic        rdy_nxt;
  logic [31:0] cnt_nxt;
  logic [63:0] sig_nxt;
  logic        err_nxt;
  logic [31:0] idx_nxt;
  logic        done_nxt;
  logic        xfer;
  logic        stall_ok;

`ifdef CPU_SINK_CHECK_EN
  logic [63:0] rx_word_q, rx_word_nxt;
  logic [63:0] expected_q, expected_nxt;
  logic [31:0] step_cnt_q, step_cnt_nxt;

  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x >> 12);
    t = t ^ (t << 25);
    t = t ^ (t >> 27);
    return t * XS_MULT;
  endfunction
`else
  // Upper index bits only seed the checker, which is not built here.
  logic unused_cpu_index_hi;
  assign unused_cpu_index_hi = ^cpu_index[31:16];
`endif

  assign xfer     = data_vld && data_rdy;
  assign stall_ok = (lfsr_q[3:0] >= STALL_W);
  // Fibonacci taps 16,14,13,11
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_nxt = state_q;
    rdy_nxt   = data_rdy;
    cnt_nxt   = rx_count;
    sig_nxt   = signature;
    err_nxt   = error;
    idx_nxt   = first_err_idx;
    done_nxt  = done;
`ifdef CPU_SINK_CHECK_EN
    rx_word_nxt  = rx_word_q;
    expected_nxt = expected_q;
    step_cnt_nxt = step_cnt_q;
`endif
    case (state_q)
      S_READY: begin
        if (xfer) begin
          cnt_nxt = rx_count + 32'd1;
          sig_nxt = {signature[62:0], signature[63]} ^ data;
          rdy_nxt = 1'b0;
`ifdef CPU_SINK_CHECK_EN
          rx_word_nxt  = data;
          step_cnt_nxt = 32'(ITERATIONS);
          state_nxt    = S_CHECK;
`endif
        end else if (transactions_done && !data_vld) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          rdy_nxt   = 1'b0;
          if (rx_count != EXP_NB) err_nxt = 1'b1;
        end else begin
          rdy_nxt = stall_ok;
        end
      end
`ifdef CPU_SINK_CHECK_EN
      S_CHECK: begin
        rdy_nxt = 1'b0;
        if (step_cnt_q == 32'd0) begin
          if (expected_q != rx_word_q) begin
            err_nxt = 1'b1;
            if (first_err_idx == 32'hFFFF_FFFF) idx_nxt = rx_count - 32'd1;
          end
          // Following the received word resynchronises after a corrupt word
          // so one bad word does not cascade into a stream of mismatches.
          expected_nxt = rx_word_q;
          state_nxt    = S_READY;
          rdy_nxt      = stall_ok;
        end else begin
          expected_nxt = xs_step(expected_q);
          step_cnt_nxt = step_cnt_q - 32'd1;
        end
      end
`endif
      S_DONE: begin
        rdy_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_READY;
        rdy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_READY;
      lfsr_q        <= cpu_index[15:0] | 16'h0001;
      data_rdy      <= 1'b0;
      rx_count      <= 32'd0;
      signature     <= 64'd0;
      error         <= 1'b0;
      first_err_idx <= 32'hFFFF_FFFF;
      done          <= 1'b0;
`ifdef CPU_SINK_CHECK_EN
      rx_word_q     <= 64'd0;
      expected_q    <= XS_SEED + {32'd0, cpu_index};
      step_cnt_q    <= 32'd0;
`endif
    end else begin
      state_q       <= state_nxt;
      lfsr_q        <= lfsr_nxt;
      data_rdy      <= rdy_nxt;
      rx_count      <= cnt_nxt;
      signature     <= sig_nxt;
      error         <= err_nxt;
      first_err_idx <= idx_nxt;
      done          <= done_nxt;
`ifdef CPU_SINK_CHECK_EN
      rx_word_q     <= rx_word_nxt;
      expected_q    <= expected_nxt;
      step_cnt_q    <= step_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_sink.sv
// Bench for cpu_sink. Two instances with zero stall weight:
//   u_dut0: EXPECTED_NB=2, ITERATIONS=1
//   u_dut1: EXPECTED_NB=3, ITERATIONS=100
// A transaction-level model tracks the expected outputs of both instances and
// is compared against them every cycle; directed sequences add literal checks.
module tb_cpu_sink;

  localparam logic [63:0] SEED0 = 64'hdeadbeefdeadbeef;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic [31:0] cpu_index [2];
  logic        data_vld  [2];
  logic [63:0] data      [2];
  logic        tdone     [2];
  logic        data_rdy  [2];
  logic [31:0] rx_count  [2];
  logic [63:0] signature [2];
  logic        error     [2];
  logic [31:0] first_err_idx [2];
  logic        done      [2];

  cpu_sink #(.EXPECTED_NB(2), .ITERATIONS(1), .STALL_WEIGHT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cpu_index(cpu_index[0]), .data_vld(data_vld[0]),
    .data(data[0]), .transactions_done(tdone[0]), .data_rdy(data_rdy[0]),
    .rx_count(rx_count[0]), .signature(signature[0]), .error(error[0]),
    .first_err_idx(first_err_idx[0]), .done(done[0]));

  cpu_sink #(.EXPECTED_NB(3), .ITERATIONS(100), .STALL_WEIGHT(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cpu_index(cpu_index[1]), .data_vld(data_vld[1]),
    .data(data[1]), .transactions_done(tdone[1]), .data_rdy(data_rdy[1]),
    .rx_count(rx_count[1]), .signature(signature[1]), .error(error[1]),
    .first_err_idx(first_err_idx[1]), .done(done[1]));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int u, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h t=%0t", name, u, act, exp, $time);
    end
  endtask

  function automatic int exp_nb(input int u);
    return (u == 0) ? 2 : 3;
  endfunction

  function automatic int iters(input int u);
    return (u == 0) ? 1 : 100;
  endfunction

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x >> 12);
    t = t ^ (t << 25);
    t = t ^ (t >> 27);
    return t * 64'h5821657736338717;
  endfunction

  function automatic logic [63:0] xsn(input logic [63:0] x, input int n);
    logic [63:0] t;
    t = x;
    for (int i = 0; i < n; i++) t = xs(t);
    return t;
  endfunction

  // ---------------- transaction-level model ----------------
  logic        m_valid = 1'b0;
  logic        m_rdy  [2];
  logic [31:0] m_cnt  [2];
  logic [63:0] m_sig  [2];
  logic        m_err  [2];
  logic [31:0] m_idx  [2];
  logic        m_done [2];
  int          m_wait [2];   // cycles until the pending check resolves
  logic        m_pmis [2];
  logic [31:0] m_pidx [2];
`ifdef CPU_SINK_CHECK_EN
  logic [63:0] m_exp  [2];
`endif

  always @(posedge clk) begin
    m_valid <= 1'b1;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n[u]) begin
        m_rdy[u]  <= 1'b0;
        m_cnt[u]  <= 32'd0;
        m_sig[u]  <= 64'd0;
        m_err[u]  <= 1'b0;
        m_idx[u]  <= 32'hFFFF_FFFF;
        m_done[u] <= 1'b0;
        m_wait[u] <= 0;
        m_pmis[u] <= 1'b0;
        m_pidx[u] <= 32'd0;
`ifdef CPU_SINK_CHECK_EN
        m_exp[u]  <= SEED0 + 64'(cpu_index[u]);
`endif
      end else if (m_done[u]) begin
        m_rdy[u] <= 1'b0;
      end else if (m_wait[u] != 0) begin
        m_wait[u] <= m_wait[u] - 1;
        if (m_wait[u] == 1) begin
          m_rdy[u] <= 1'b1;
          if (m_pmis[u]) begin
            m_err[u] <= 1'b1;
            if (m_idx[u] == 32'hFFFF_FFFF) m_idx[u] <= m_pidx[u];
          end
        end else begin
          m_rdy[u] <= 1'b0;
        end
      end else if (data_vld[u] && m_rdy[u]) begin
        m_cnt[u] <= m_cnt[u] + 32'd1;
        m_sig[u] <= {m_sig[u][62:0], m_sig[u][63]} ^ data[u];
        m_rdy[u] <= 1'b0;
`ifdef CPU_SINK_CHECK_EN
        m_wait[u] <= iters(u) + 1;
        m_pmis[u] <= (xsn(m_exp[u], iters(u)) != data[u]);
        m_pidx[u] <= m_cnt[u];
        m_exp[u]  <= data[u];
`endif
      end else if (tdone[u] && !data_vld[u]) begin
        m_done[u] <= 1'b1;
        m_rdy[u]  <= 1'b0;
        if (m_cnt[u] != 32'(exp_nb(u))) m_err[u] <= 1'b1;
      end else begin
        m_rdy[u] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int u = 0; u < 2; u++) begin
        chk("data_rdy",      u, 64'(data_rdy[u]),      64'(m_rdy[u]));
        chk("rx_count",      u, 64'(rx_count[u]),      64'(m_cnt[u]));
        chk("signature",     u, signature[u],          m_sig[u]);
        chk("error",         u, 64'(error[u]),         64'(m_err[u]));
        chk("first_err_idx", u, 64'(first_err_idx[u]), 64'(m_idx[u]));
        chk("done",          u, 64'(done[u]),          64'(m_done[u]));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at a negedge.
  task automatic send(input int u, input logic [63:0] w);
    int n;
    n = 0;
    data_vld[u] = 1'b1;
    data[u]     = w;
    while (!data_rdy[u] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!data_rdy[u]) begin
      chk("send_timeout_rdy", u, 64'(data_rdy[u]), 64'd1);
      data_vld[u] = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      data_vld[u] = 1'b0;
    end
  endtask

  task automatic do_reset(input int u);
    rst_n[u] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n[u] = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u]     = 1'b0;
      data_vld[u]  = 1'b1;
      data[u]      = 64'hAAAA_5555_AAAA_5555;
      tdone[u]     = 1'b0;
    end
    cpu_index[0] = 32'd0;
    cpu_index[1] = 32'd3;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_rdy",   u, 64'(data_rdy[u]),      64'd0);
      chk("rst_cnt",   u, 64'(rx_count[u]),      64'd0);
      chk("rst_sig",   u, signature[u],          64'd0);
      chk("rst_err",   u, 64'(error[u]),         64'd0);
      chk("rst_idx",   u, 64'(first_err_idx[u]), 64'hFFFF_FFFF);
      rst_n[u]    = 1'b1;
      data_vld[u] = 1'b0;
    end

`ifndef CPU_SINK_CHECK_EN
    fork
      begin send(0, 64'h1); send(0, 64'h3); end
      begin send(1, 64'h1); send(1, 64'h3); end
    join
    for (int u = 0; u < 2; u++) begin
      chk("lit_sig",       u, signature[u],     64'h1);
      chk("lit_model_sig", u, m_sig[u],         64'h1);
      chk("lit_cnt",       u, 64'(rx_count[u]), 64'd2);
      tdone[u] = 1'b1;
    end
    @(negedge clk);
    chk("lit_done", 0, 64'(done[0]),  64'd1);
    chk("lit_err",  0, 64'(error[0]), 64'd0);
    chk("lit_done", 1, 64'(done[1]),  64'd1);
    chk("lit_err",  1, 64'(error[1]), 64'd1);
    chk("lit_idx",  1, 64'(first_err_idx[1]), 64'hFFFF_FFFF);
    // words offered after done are ignored
    data_vld[0] = 1'b1; data[0] = 64'h77;
    repeat (4) @(negedge clk);
    data_vld[0] = 1'b0;
    chk("lit_cnt_after_done", 0, 64'(rx_count[0]), 64'd2);
    // transfer and transactions_done in the same cycle
    tdone[0] = 1'b0;
    tdone[1] = 1'b0;
    fork
      do_reset(0);
      do_reset(1);
    join
    chk("lit_done_cleared", 0, 64'(done[0]), 64'd0);
    tdone[0] = 1'b1;
    send(0, 64'h5);
    @(negedge clk);
    chk("lit_same_cycle_cnt",  0, 64'(rx_count[0]), 64'd1);
    chk("lit_same_cycle_sig",  0, signature[0],     64'h5);
    chk("lit_same_cycle_done", 0, 64'(done[0]),     64'd1);
    chk("lit_same_cycle_err",  0, 64'(error[0]),    64'd1);
    repeat (3) @(negedge clk);
`else
    fork
      begin
        logic [63:0] w0, w1b, w2;
        w0  = xs(SEED0);
        w1b = xs(w0) + 64'd1;
        w2  = xs(w1b);
        send(0, w0);
        repeat (4) @(negedge clk);
        chk("lit_err_good_word", 0, 64'(error[0]), 64'd0);
        send(0, w1b);
        repeat (4) @(negedge clk);
        chk("lit_err_bad_word", 0, 64'(error[0]),         64'd1);
        chk("lit_idx_bad_word", 0, 64'(first_err_idx[0]), 64'd1);
        send(0, w2);
        repeat (4) @(negedge clk);
        chk("lit_idx_resync",   0, 64'(first_err_idx[0]), 64'd1);
        chk("lit_cnt",          0, 64'(rx_count[0]),      64'd3);
      end
      begin
        send(1, 64'h55);
        repeat (50) @(negedge clk);
        do_reset(1);
        chk("lit_cnt_after_rst", 1, 64'(rx_count[1]), 64'd0);
        send(1, xsn(SEED0 + 64'd3, 100));
        repeat (110) @(negedge clk);
        chk("lit_err_after_rst", 1, 64'(error[1]),         64'd0);
        chk("lit_cnt_one",       1, 64'(rx_count[1]),      64'd1);
        chk("lit_idx_none",      1, 64'(first_err_idx[1]), 64'hFFFF_FFFF);
      end
    join
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sink.md
# cpu_sink

Receiving end of the per-CPU data stream. Accepts 64-bit words over the `data_vld`/`data_rdy` handshake, applies pseudo-random backpressure, and counts and signs every accepted word. It optionally re-derives the expected xorshift64* sequence to flag corrupted or missing words, then raises `done` once the producer reports `transactions_done`. One instance sits opposite each CPU in the multi-CPU testbench.

## Interface
- `EXPECTED_NB`, 1000: number of words the producer must deliver.
- `ITERATIONS`, 20000000: xorshift64* steps between consecutive producer words; checker only.
- `STALL_WEIGHT`, 4: 0..15; larger values mean more backpressure.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `cpu_index`  in  32  producer index; sets the checker seed and LFSR seed; stable after reset
- `data_vld`  in  1  producer word valid
- `data`  in  64  producer word
- `transactions_done`  in  1  producer finished (sticky on producer side)
- `data_rdy`  out  1  sink ready; registered
- `rx_count`  out  32  words accepted
- `signature`  out  64  running signature of accepted words
- `error`  out  1  sticky mismatch or count error
- `first_err_idx`  out  32  index of the first mismatching word; 0xFFFFFFFF if none
- `done`  out  1  sticky end-of-test

## Operation
- Transfer: at a posedge with `data_vld && data_rdy` sampled high.
- States:
  - READY: accepting words.
  - CHECK: checker busy; present only with the macro.
  - DONE: terminal.
- Reset (`rst_n` low at posedge), whatever the current state:
  - state goes to READY.
  - `data_rdy`=0, `rx_count`=0, `signature`=0, `error`=0, `first_err_idx`=0xFFFFFFFF, `done`=0.
  - LFSR is loaded with `{cpu_index[15:0]} | 16'h1`; never zero.
  - `expected` is loaded with 64'hdeadbeefdeadbeef + `cpu_index`, mod 2^64.
- Backpressure LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle outside reset.
  - In READY, next `data_rdy` = (`lfsr[3:0]` >= `STALL_WEIGHT`) and no transfer this cycle.
- On each transfer:
  - `rx_count` += 1; wraps modulo 2^32.
  - `signature` <= rotl64(`signature`,1) ^ `data`.
  - `data` is latched into `rx_word`.
- Done detection: in READY, with `transactions_done`=1, `data_vld`=0 and no transfer → DONE.
  - `done` <= 1; `data_rdy` <= 0.
  - If `rx_count` != `EXPECTED_NB`, then `error` <= 1.
  - `first_err_idx` is unchanged.
- DONE: holds all outputs; `data_rdy`=0; only reset leaves it.
- A transfer and `transactions_done` in the same cycle: the transfer is taken; the done check is re-evaluated after that word is handled.

## Timing
- `data_rdy` is forced 0 in the cycle after every transfer; minimum one-cycle bubble.
- `rx_count` and `signature` update one cycle after the transfer edge.
- Without the macro: maximum throughput is one word every 2 cycles.
- With the macro: a transfer moves the sink to CHECK for `ITERATIONS` cycles with `data_rdy`=0. Each cycle, one xorshift64* step is applied to `expected`:
  - x^=x>>12; x^=x<<25; x^=x>>27; x*=64'h5821657736338717; all mod 2^64.
  - A 32-bit step counter counts down.
- Compare: at the cycle the counter hits 0, `expected` is compared with `rx_word`.
  - On mismatch: `error` <= 1. If `first_err_idx` is still all-ones, it takes `rx_count`-1.
  - On mismatch, `expected` is then set to `rx_word`; the checker resynchronises to the producer stream.
  - Return to READY; `data_rdy` may rise on the following cycle.
- Per-word latency with the macro: `ITERATIONS`+1 cycles from transfer to compare.
- `ITERATIONS`=0: the compare happens the cycle after the transfer, with no step applied.

## Configuration
- `CPU_SINK_CHECK_EN` defined:
  - the CHECK state, `expected` register, step counter and comparator are compiled in.
  - mismatches set `error` and `first_err_idx`.
- Not defined:
  - that logic is removed.
  - `error` is driven only by the `rx_count` check at done.
  - `first_err_idx` stays constant at 0xFFFFFFFF.
  - `ITERATIONS` is ignored.

## Test plan
- Reset with `rst_n`=0 for 3 cycles while `data_vld`=1:
  - `data_rdy`=0, `rx_count`=0, `signature`=0, `error`=0, `first_err_idx`=0xFFFFFFFF during reset.
  - no transfer counted.
- `STALL_WEIGHT`=0, macro off, send 0x1 then 0x3:
  - `signature`=0x1, `rx_count`=2.
  - `data_rdy` low the cycle after each transfer.
- `EXPECTED_NB`=2 with the two words above, then `transactions_done`=1:
  - `done`=1 one cycle later, `error`=0.
- Same, but `EXPECTED_NB`=3:
  - `done`=1 and `error`=1.
- Macro on, `ITERATIONS`=1, `cpu_index`=0; send the correct next word, then an off-by-one word, then the correct successor of the corrupted word:
  - `error`=1, `first_err_idx`=1.
  - the third word does not re-raise a new index.
- Reset asserted mid-CHECK (macro on, `ITERATIONS`=100, after 50 cycles):
  - state READY, `rx_count`=0, `expected` reseeded.
  - next correct first word passes with `error`=0.
